// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage -- decode, forwarding, load-use bubble.
// Optional event counters are compiled in with `define ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            exm_regwrite,
  input  logic [REGW-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [REGW-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  input  logic            stall,
  input  logic            flush,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_op,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_is_load,
  output logic            ex_is_store,
  output logic            ex_branch,
  output logic            ex_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_bubbles,
  output logic [31:0]     stat_flushes
`endif
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_BLT = 4'b1000;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_JAL = 4'b1110;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic {ISSUE, BUBBLE} state_t;

  state_t          r_state;
  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [3:0]      r_op;
  logic [REGW-1:0] r_rd;
  logic            r_rw;
  logic            r_ld;
  logic            r_st;
  logic            r_br;
  logic            r_ill;

  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic [XLEN-1:0] w_b;
  logic [3:0]      w_op;
  logic            w_ill;
  logic            w_rw;
  logic            w_ld;
  logic            w_st;
  logic            w_br;
  logic            w_use1;
  logic            w_use2;
  logic            w_loaduse;
  logic            w_hz;

  // rs1 operand: EX/MEM beats MEM/WB beats register file, x0 never forwarded
  always_comb begin
    w_fwd1 = id_rs1_data;
    if (exm_regwrite && exm_rd != '0 && exm_rd == id_rs1)
      w_fwd1 = exm_result;
    else if (mwb_regwrite && mwb_rd != '0 && mwb_rd == id_rs1)
      w_fwd1 = mwb_data;
  end

  // rs2 operand: same forwarding priority as rs1
  always_comb begin
    w_fwd2 = id_rs2_data;
    if (exm_regwrite && exm_rd != '0 && exm_rd == id_rs2)
      w_fwd2 = exm_result;
    else if (mwb_regwrite && mwb_rd != '0 && mwb_rd == id_rs2)
      w_fwd2 = mwb_data;
  end

  // opcode/funct decode into ALU op, b-operand select and control flags
  always_comb begin
    w_op   = OP_AND;
    w_b    = w_fwd2;
    w_ill  = 1'b0;
    w_rw   = 1'b0;
    w_ld   = 1'b0;
    w_st   = 1'b0;
    w_br   = 1'b0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    unique case (1'b1)
      (id_opcode == OPC_R): begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_rw   = 1'b1;
        unique case (id_funct3)
          3'b000:  w_op = id_funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  w_op = OP_AND;
          3'b110:  w_op = OP_OR;
          default: w_ill = 1'b1;
        endcase
      end
      (id_opcode == OPC_I): begin
        w_use1 = 1'b1;
        w_rw   = 1'b1;
        w_b    = id_imm;
        unique case (id_funct3)
          3'b000: w_op = OP_ADD;
          3'b001: begin
            w_op = OP_SLL;
            w_b  = {{(XLEN-6){1'b0}}, id_imm[5:0]};
          end
          3'b111:  w_op = OP_AND;
          3'b110:  w_op = OP_OR;
          default: w_ill = 1'b1;
        endcase
      end
      (id_opcode == OPC_LD): begin
        w_use1 = 1'b1;
        w_rw   = 1'b1;
        w_ld   = 1'b1;
        w_op   = OP_ADD;
        w_b    = id_imm;
      end
      (id_opcode == OPC_ST): begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_st   = 1'b1;
        w_op   = OP_ADD;
        w_b    = id_imm;
      end
      (id_opcode == OPC_BR): begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_br   = 1'b1;
        unique case (id_funct3)
          3'b000:  w_op = OP_BEQ;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          default: w_ill = 1'b1;
        endcase
      end
      (id_opcode == OPC_JAL): begin
        w_op = OP_JAL;
        w_br = 1'b1;
        w_rw = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_op   = OP_AND;
      w_rw   = 1'b0;
      w_ld   = 1'b0;
      w_st   = 1'b0;
      w_br   = 1'b0;
      w_use1 = 1'b0;
      w_use2 = 1'b0;
    end
  end

  // load in EX feeding a used source of the decoding instruction
  always_comb begin
    w_loaduse = r_valid && r_ld && r_rd != '0 && id_valid &&
                ((w_use1 && r_rd == id_rs1) || (w_use2 && r_rd == id_rs2));
    w_hz = (r_state == ISSUE) && w_loaduse && !flush && !stall;
  end

  assign hazard_stall = w_hz;

  // ID/EX register and issue FSM: reset > flush > stall > hazard > normal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ISSUE;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_br    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush || (!stall && (w_hz || !id_valid))) begin
      r_state <= w_hz ? BUBBLE : ISSUE;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_br    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (!stall) begin
      r_state <= ISSUE;
      r_valid <= 1'b1;
      r_a     <= w_fwd1;
      r_b     <= w_b;
      r_op    <= w_op;
      r_rd    <= id_rd;
      r_rw    <= w_rw;
      r_ld    <= w_ld;
      r_st    <= w_st;
      r_br    <= w_br;
      r_ill   <= w_ill;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_a        = r_a;
  assign ex_b        = r_b;
  assign ex_alu_op   = r_op;
  assign ex_rd       = r_rd;
  assign ex_regwrite = r_rw;
  assign ex_is_load  = r_ld;
  assign ex_is_store = r_st;
  assign ex_branch   = r_br;
  assign ex_illegal  = r_ill;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] r_issued;
  logic [31:0] r_bubbles;
  logic [31:0] r_flushes;

  // event counters, frozen while the boundary is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issued  <= '0;
      r_bubbles <= '0;
      r_flushes <= '0;
    end else if (!stall) begin
      if (flush)
        r_flushes <= r_flushes + 32'd1;
      else if (w_hz)
        r_bubbles <= r_bubbles + 32'd1;
      else if (id_valid)
        r_issued <= r_issued + 32'd1;
    end
  end

  assign stat_issued  = r_issued;
  assign stat_bubbles = r_bubbles;
  assign stat_flushes = r_flushes;
`endif

endmodule
